tl_width_narrow: RTL and testbench
==================================

# tl_width_narrow

Parametrised TileLink-UH width converter joining a wide inner port (IN_BYTES data bus) to a narrower outer port (OUT_BYTES data bus). On A, each wide data beat is split into ratio-many narrow beats, or fewer for sub-beat sizes. On D, narrow response beats are gathered back into wide beats. The block sits on the crossbar edge where it replaces the equal-width pass-through adapter whenever master and slave bus widths differ. It carries the same monitored A/D fields, including the seven amba_prot user bits.

## Interface
- IN_BYTES, 8: inner data bytes per beat; power of two.
- OUT_BYTES, 4: outer data bytes per beat; power of two, < IN_BYTES.
- SIZE_W, 3: width of the size field (log2 bytes).
- SOURCE_W, 2: source ID width; sizes the lane table.
- ADDR_W, 32: address width.
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_a_*  in/out  —  inner A channel:
  - valid, ready.
  - opcode[3], param[3], size[SIZE_W], source[SOURCE_W], address[ADDR_W].
  - prot[7] (bufferable, modifiable, readalloc, writealloc, privileged, secure, fetch).
  - mask[IN_BYTES], data[8*IN_BYTES], corrupt.
- out_a_*  out/in  —  same fields as in_a_*; mask[OUT_BYTES], data[8*OUT_BYTES].
- in_d_*  out/in  —  inner D channel:
  - valid, ready.
  - opcode[3], size[SIZE_W], source[SOURCE_W], denied.
  - data[8*IN_BYTES], corrupt.
- out_d_*  in/out  —  same fields as in_d_*; data[8*OUT_BYTES].

## Operation
- Constants: RATIO = IN_BYTES/OUT_BYTES; LO = log2(OUT_BYTES); LW = log2(RATIO).
- Outer beats per inner beat: N = 1 if size ≤ LO; N = RATIO if size ≥ log2(IN_BYTES); otherwise N = 2^(size−LO).
- Starting lane:
  - L0 = address[LO+LW−1:LO] when size < log2(IN_BYTES).
  - L0 = 0 otherwise.
- A channel, Put opcodes (0 = PutFull, 1 = PutPartial):
  - Emit N outer beats at lanes L0 … L0+N−1.
  - Each outer beat carries the matching lane slice of data and mask.
  - Address is advanced by OUT_BYTES per sub-beat.
  - Every other field is copied unchanged.
- A channel, Get (opcode 4):
  - Emit exactly one outer beat.
  - Mask is the lane-L0 slice when size ≤ LO; all-ones otherwise.
- A sub-beat counter a_cnt (LW bits) runs 0 … N−1.
- in_a_ready = out_a_ready && (a_cnt == N−1). The inner beat is consumed only on its last outer sub-beat.
- Lane table, one entry per source (LW bits each):
  - Written with L0 on the first outer beat of each A message (first inner beat, a_cnt = 0).
  - First-beat tracking uses an inner beat counter derived from size.
- D channel, AccessAckData (opcode 1):
  - Gather N outer beats (N computed from d size), starting at the table lane for d source.
  - Lanes 0 … N−2 are stored in a gather register.
  - The last outer beat is forwarded combinationally together with the stored lanes.
  - Unfilled lanes read 0.
  - denied and corrupt are OR-accumulated across the sub-beats.
- D channel, AccessAck (opcode 0) and other data-less opcodes: single beat passed through; lane table not used.
- out_d_ready = (d_cnt != N−1) || in_d_ready.
- in_d_valid = out_d_valid && (d_cnt == N−1).

## Timing
- Reset (reset = 0, asynchronous): a_cnt, d_cnt, inner beat counters, gather register, denied/corrupt accumulators and lane table all clear to 0.
- Outputs during reset:
  - out_a_valid = in_a_valid (combinational).
  - in_d_valid = 0 unless a single-beat D is presented.
  - in_a_ready = out_a_ready when N = 1.
- Latency: A path 0 cycles per sub-beat. D path 0 cycles from the last outer beat to the inner beat. No bubbles between sub-beats when both sides stay ready.
- Handshake rules:
  - A-side fields stay stable while an inner beat is split, since the inner beat is not yet acked.
  - A valid-without-ready sub-beat holds a_cnt.
  - Counters wrap to 0 after N−1.
- Simultaneous events:
  - A table write and a D read of the same source in one cycle: D sees the old value. Legal, because a source is reused only after its D completes.
  - D stalled on the last beat (in_d_ready = 0): out_d_ready = 0; the gather register holds.
- Reset mid-burst: counters return to 0; the partially sent message is abandoned, with no recovery.

## Structure
- Shared package tl_pkg holds:
  - opcode constants: PUT_FULL = 0, PUT_PARTIAL = 1, GET = 4, ACK = 0, ACK_DATA = 1.
  - the beats-from-size function.
  - the amba_prot bundle typedef.
- One sub-module, tl_width_lane_table: a 2^SOURCE_W × LW register file with one write port, one asynchronous read port and asynchronous reset.
- The existing TLMonitor is instantiated on the inner port by the parent, not inside this block.

## Test plan
All cases use IN_BYTES = 8, OUT_BYTES = 4.
- PutFull, size 3, address 0x100, data 0x1122334455667788, mask 0xFF:
  - out beat 1: address 0x100, data 0x55667788, mask 0xF.
  - out beat 2: address 0x104, data 0x11223344.
  - in_a_ready high only on beat 2.
- PutPartial, size 2, address 0x104, mask 0xF0: one out beat, data = upper word, mask 0xF; in_a_ready in the same cycle.
- Get, size 2, address 0x0C, source 3, then AccessAckData beat 0xDEADBEEF: in_d_data = 0xDEADBEEF_00000000; in_d_valid in the same cycle as out_d_valid.
- Get, size 4, source 1, returning 4 outer beats A, B, C, D: inner beat {B, A}, then {D, C}. denied is set on beat C only → asserted on the second inner beat only.
- Back-pressure: in_d_ready = 0 during the last sub-beat → out_d_ready = 0 and the data is held. Release → the inner beat fires and d_cnt returns to 0.
- Assert reset after the first sub-beat of a PutFull → a_cnt = 0; the next PutFull starts at lane 0.

Source files
------------

// File: rtl/tl_pkg.sv
// rtl/tl_pkg.sv - shared TileLink-UH opcodes, amba_prot bundle and beat-count helper
package tl_pkg;

  localparam logic [2:0] PUT_FULL    = 3'd0;
  localparam logic [2:0] PUT_PARTIAL = 3'd1;
  localparam logic [2:0] GET         = 3'd4;
  localparam logic [2:0] ACK         = 3'd0;
  localparam logic [2:0] ACK_DATA    = 3'd1;

  typedef struct packed {
    logic bufferable;
    logic modifiable;
    logic readalloc;
    logic writealloc;
    logic privileged;
    logic secure;
    logic fetch;
  } amba_prot_t;

  // Narrow beats needed to carry one wide beat of a 2^size byte transfer.
  function automatic int unsigned beats_from_size(input int unsigned size,
                                                  input int unsigned lo,
                                                  input int unsigned li);
    int unsigned n;
    if (size <= lo)
      n = 1;
    else if (size >= li)
      n = 1 << (li - lo);
    else
      n = 1 << (size - lo);
    return n;
  endfunction

endpackage

// File: rtl/tl_width_narrow_if.sv
// rtl/tl_width_narrow_if.sv - TileLink-UH A/D channel bundle with master/slave views
interface tl_width_narrow_if #(
  parameter int DATA_BYTES = 8,
  parameter int SIZE_W     = 3,
  parameter int SOURCE_W   = 2,
  parameter int ADDR_W     = 32
);
  import tl_pkg::*;

  logic                    a_valid;
  logic                    a_ready;
  logic [2:0]              a_opcode;
  logic [2:0]              a_param;
  logic [SIZE_W-1:0]       a_size;
  logic [SOURCE_W-1:0]     a_source;
  logic [ADDR_W-1:0]       a_address;
  amba_prot_t              a_prot;
  logic [DATA_BYTES-1:0]   a_mask;
  logic [8*DATA_BYTES-1:0] a_data;
  logic                    a_corrupt;

  logic                    d_valid;
  logic                    d_ready;
  logic [2:0]              d_opcode;
  logic [SIZE_W-1:0]       d_size;
  logic [SOURCE_W-1:0]     d_source;
  logic                    d_denied;
  logic [8*DATA_BYTES-1:0] d_data;
  logic                    d_corrupt;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_prot,
           a_mask, a_data, a_corrupt,
    input  a_ready,
    input  d_valid, d_opcode, d_size, d_source, d_denied, d_data, d_corrupt,
    output d_ready
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_prot,
           a_mask, a_data, a_corrupt,
    output a_ready,
    output d_valid, d_opcode, d_size, d_source, d_denied, d_data, d_corrupt,
    input  d_ready
  );

endinterface

// File: rtl/tl_width_lane_table.sv
// rtl/tl_width_lane_table.sv - per-source starting-lane register file
module tl_width_lane_table #(
  parameter int SOURCE_W = 2,
  parameter int LW       = 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_we,
  input  logic [SOURCE_W-1:0] i_waddr,
  input  logic [LW-1:0]       i_wdata,
  input  logic [SOURCE_W-1:0] i_raddr,
  output logic [LW-1:0]       o_rdata
);

  logic [LW-1:0] r_lane [2**SOURCE_W];

  // Record the starting lane of each outstanding request, one slot per source.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 2**SOURCE_W; i++) r_lane[i] <= '0;
    end else if (i_we) begin
      r_lane[i_waddr] <= i_wdata;
    end
  end

  // Same-cycle write and read of one source returns the previous entry.
  assign o_rdata = r_lane[i_raddr];

endmodule

// File: rtl/tl_width_narrow.sv
// rtl/tl_width_narrow.sv - TileLink-UH wide-to-narrow width converter
module tl_width_narrow
  import tl_pkg::*;
#(
  parameter int IN_BYTES  = 8,
  parameter int OUT_BYTES = 4,
  parameter int SIZE_W    = 3,
  parameter int SOURCE_W  = 2,
  parameter int ADDR_W    = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  tl_width_narrow_if.slave  i_inner,
  tl_width_narrow_if.master o_outer
);

  localparam int unsigned RATIO = IN_BYTES / OUT_BYTES;
  localparam int unsigned LO    = $clog2(OUT_BYTES);
  localparam int unsigned LI    = $clog2(IN_BYTES);
  localparam int unsigned LW    = LI - LO;
  localparam int unsigned OW    = 8 * OUT_BYTES;
  // Inner beats of the largest message minus one must fit this counter.
  localparam int unsigned IBW   = (((1 << SIZE_W) - 1) > LI) ? ((1 << SIZE_W) - 1 - LI) : 1;

  // ---------------- A channel ----------------
  logic [LW-1:0]                 r_a_cnt;
  logic [IBW-1:0]                r_a_ibeat;
  logic                          w_a_split;
  logic                          w_a_small;
  logic                          w_a_sub_lane;
  logic [LW-1:0]                 w_a_l0;
  logic [LW-1:0]                 w_a_lane;
  logic [LW-1:0]                 w_a_cnt_max;
  logic [IBW-1:0]                w_a_ibeat_max;
  logic                          w_a_last;
  logic                          w_a_fire;
  logic                          w_tbl_we;
  logic [RATIO-1:0][OW-1:0]      w_a_data_lanes;
  logic [RATIO-1:0][OUT_BYTES-1:0] w_a_mask_lanes;

  // Opcodes 0..3 carry data and are split; Get and hints travel as one beat.
  assign w_a_split    = ~i_inner.a_opcode[2];
  assign w_a_small    = 32'(i_inner.a_size) < LI;
  assign w_a_sub_lane = 32'(i_inner.a_size) <= LO;
  assign w_a_l0       = w_a_small ? i_inner.a_address[LO +: LW] : '0;
  assign w_a_cnt_max  = w_a_split ? LW'(beats_from_size(32'(i_inner.a_size), LO, LI) - 1) : '0;
  assign w_a_lane     = w_a_l0 + r_a_cnt;
  assign w_a_last     = (r_a_cnt == w_a_cnt_max);
  assign w_a_fire     = i_inner.a_valid & o_outer.a_ready;

  // Number of inner beats in the current message, minus one.
  always_comb begin
    w_a_ibeat_max = '0;
    if (w_a_split && (32'(i_inner.a_size) > LI))
      w_a_ibeat_max = IBW'((32'd1 << (32'(i_inner.a_size) - LI)) - 32'd1);
  end

  assign w_a_data_lanes = i_inner.a_data;
  assign w_a_mask_lanes = i_inner.a_mask;

  assign o_outer.a_valid   = i_inner.a_valid;
  assign o_outer.a_opcode  = i_inner.a_opcode;
  assign o_outer.a_param   = i_inner.a_param;
  assign o_outer.a_size    = i_inner.a_size;
  assign o_outer.a_source  = i_inner.a_source;
  assign o_outer.a_prot    = i_inner.a_prot;
  assign o_outer.a_corrupt = i_inner.a_corrupt;
  assign o_outer.a_address = i_inner.a_address + (ADDR_W'(r_a_cnt) << LO);
  assign o_outer.a_data    = w_a_data_lanes[w_a_lane];
  assign o_outer.a_mask    = (w_a_split || w_a_sub_lane) ? w_a_mask_lanes[w_a_lane] : '1;
  // The wide beat is only acknowledged with its final narrow sub-beat.
  assign i_inner.a_ready   = o_outer.a_ready & w_a_last;

  // Only the very first narrow beat of a message records the starting lane.
  assign w_tbl_we = w_a_fire & (r_a_cnt == '0) & (r_a_ibeat == '0);

  // Advance the sub-beat counter per narrow beat and the inner counter per wide beat.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a_cnt   <= '0;
      r_a_ibeat <= '0;
    end else if (w_a_fire) begin
      if (w_a_last) begin
        r_a_cnt   <= '0;
        r_a_ibeat <= (r_a_ibeat == w_a_ibeat_max) ? '0 : r_a_ibeat + 1'b1;
      end else begin
        r_a_cnt   <= r_a_cnt + 1'b1;
      end
    end
  end

  // ---------------- Lane table ----------------
  logic [LW-1:0] w_tbl_lane;

  tl_width_lane_table #(
    .SOURCE_W (SOURCE_W),
    .LW       (LW)
  ) u_lane_table (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_we    (w_tbl_we),
    .i_waddr (i_inner.a_source),
    .i_wdata (w_a_l0),
    .i_raddr (o_outer.d_source),
    .o_rdata (w_tbl_lane)
  );

  // ---------------- D channel ----------------
  logic [LW-1:0]            r_d_cnt;
  logic [RATIO-1:0][OW-1:0] r_gather;
  logic                     r_d_denied;
  logic                     r_d_corrupt;
  logic                     w_d_has_data;
  logic [LW-1:0]            w_d_cnt_max;
  logic [LW-1:0]            w_d_lane;
  logic                     w_d_last;
  logic                     w_d_fire;
  logic [RATIO-1:0][OW-1:0] w_d_data_lanes;

  assign w_d_has_data = (o_outer.d_opcode == ACK_DATA);
  assign w_d_cnt_max  = w_d_has_data ? LW'(beats_from_size(32'(o_outer.d_size), LO, LI) - 1) : '0;
  assign w_d_lane     = w_d_has_data ? (w_tbl_lane + r_d_cnt) : '0;
  assign w_d_last     = (r_d_cnt == w_d_cnt_max);
  assign w_d_fire     = o_outer.d_valid & o_outer.d_ready;

  // Overlay the live narrow beat onto the lanes gathered so far.
  always_comb begin
    w_d_data_lanes           = r_gather;
    w_d_data_lanes[w_d_lane] = o_outer.d_data;
  end

  assign o_outer.d_ready   = ~w_d_last | i_inner.d_ready;
  assign i_inner.d_valid   = o_outer.d_valid & w_d_last;
  assign i_inner.d_opcode  = o_outer.d_opcode;
  assign i_inner.d_size    = o_outer.d_size;
  assign i_inner.d_source  = o_outer.d_source;
  assign i_inner.d_data    = w_d_data_lanes;
  assign i_inner.d_denied  = r_d_denied | o_outer.d_denied;
  assign i_inner.d_corrupt = r_d_corrupt | o_outer.d_corrupt;

  // Collect non-final narrow beats; clear everything once the wide beat leaves.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_d_cnt     <= '0;
      r_gather    <= '0;
      r_d_denied  <= 1'b0;
      r_d_corrupt <= 1'b0;
    end else if (w_d_fire) begin
      if (w_d_last) begin
        r_d_cnt     <= '0;
        r_gather    <= '0;
        r_d_denied  <= 1'b0;
        r_d_corrupt <= 1'b0;
      end else begin
        r_d_cnt            <= r_d_cnt + 1'b1;
        r_gather[w_d_lane] <= o_outer.d_data;
        r_d_denied         <= r_d_denied | o_outer.d_denied;
        r_d_corrupt        <= r_d_corrupt | o_outer.d_corrupt;
      end
    end
  end

endmodule

// File: tb/tb_tl_width_narrow.sv
// tb/tb_tl_width_narrow.sv - self-checking bench for the 8-to-4 byte width converter
module tb_tl_width_narrow;
  import tl_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  tl_width_narrow_if #(.DATA_BYTES(8)) inner_if ();
  tl_width_narrow_if #(.DATA_BYTES(4)) outer_if ();

  tl_width_narrow dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_inner (inner_if),
    .o_outer (outer_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]       opcode;
    logic [2:0]       size;
    logic [1:0]       source;
    logic [31:0]      addr;
    logic [7:0]       mask;
    int               ninner;
    int               nper;
    logic [1:0][63:0] data;
    logic [3:0][31:0] exp_addr;
    logic [3:0][31:0] exp_data;
    logic [3:0][3:0]  exp_mask;
  } a_vec_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } a_exp_t;

  typedef struct packed {
    logic [2:0]       opcode;
    logic [2:0]       size;
    logic [1:0]       source;
    int               nout;
    int               nper;
    logic [3:0][31:0] data;
    logic [3:0]       denied;
    logic [3:0]       corrupt;
    logic [1:0][63:0] exp_data;
    logic [1:0]       exp_denied;
    logic [1:0]       exp_corrupt;
    logic             chk_data;
  } d_vec_t;

  typedef struct packed {
    logic [63:0] data;
    logic        denied;
    logic        corrupt;
    logic        chk_data;
  } d_exp_t;

  a_vec_t a_tab [6];
  d_vec_t d_tab [5];
  a_exp_t a_q [$];
  d_exp_t d_q [$];

  localparam logic [6:0] PROT = 7'b1000101;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    inner_if.a_valid   = 1'b0;
    inner_if.a_opcode  = 3'd0;
    inner_if.a_param   = 3'd0;
    inner_if.a_size    = 3'd0;
    inner_if.a_source  = 2'd0;
    inner_if.a_address = 32'd0;
    inner_if.a_prot    = PROT;
    inner_if.a_mask    = 8'd0;
    inner_if.a_data    = 64'd0;
    inner_if.a_corrupt = 1'b0;
    inner_if.d_ready   = 1'b0;
    outer_if.a_ready   = 1'b0;
    outer_if.d_valid   = 1'b0;
    outer_if.d_opcode  = 3'd0;
    outer_if.d_size    = 3'd0;
    outer_if.d_source  = 2'd0;
    outer_if.d_denied  = 1'b0;
    outer_if.d_data    = 32'd0;
    outer_if.d_corrupt = 1'b0;
  endtask

  // Starts just after a negedge; random outer back-pressure on every sub-beat.
  task automatic send_a(input a_vec_t v);
    int beat;
    int guard;
    a_exp_t e;
    for (int ib = 0; ib < v.ninner; ib++) begin
      inner_if.a_valid   = 1'b1;
      inner_if.a_opcode  = v.opcode;
      inner_if.a_size    = v.size;
      inner_if.a_source  = v.source;
      inner_if.a_address = v.addr;
      inner_if.a_mask    = v.mask;
      inner_if.a_data    = v.data[ib];
      for (int k = 0; k < v.nper; k++)
        a_q.push_back('{addr: v.exp_addr[ib*v.nper+k], data: v.exp_data[ib*v.nper+k],
                        mask: v.exp_mask[ib*v.nper+k]});
      beat  = 0;
      guard = 0;
      while (beat < v.nper && guard < 40) begin
        outer_if.a_ready = ($urandom_range(0, 3) != 0);
        #2;
        chk("out_a_valid", outer_if.a_valid, 1);
        if (outer_if.a_ready) begin
          e = a_q.pop_front();
          chk("out_a_address", outer_if.a_address, e.addr);
          chk("out_a_data", outer_if.a_data, e.data);
          chk("out_a_mask", outer_if.a_mask, e.mask);
          chk("out_a_source", outer_if.a_source, v.source);
          chk("out_a_prot", outer_if.a_prot, PROT);
          chk("in_a_ready", inner_if.a_ready, beat == v.nper - 1);
          beat++;
        end else begin
          chk("in_a_ready_stalled", inner_if.a_ready, 0);
        end
        @(posedge clk);
        @(negedge clk);
        guard++;
      end
      chk("a_sub_beats_done", beat, v.nper);
    end
    inner_if.a_valid = 1'b0;
    outer_if.a_ready = 1'b0;
  endtask

  // Starts just after a negedge; random inner back-pressure on final sub-beats.
  task automatic send_d(input d_vec_t v);
    int k;
    int guard;
    logic last;
    d_exp_t e;
    for (int i = 0; i < v.nout / v.nper; i++)
      d_q.push_back('{data: v.exp_data[i], denied: v.exp_denied[i],
                      corrupt: v.exp_corrupt[i], chk_data: v.chk_data});
    k     = 0;
    guard = 0;
    while (k < v.nout && guard < 60) begin
      outer_if.d_valid   = 1'b1;
      outer_if.d_opcode  = v.opcode;
      outer_if.d_size    = v.size;
      outer_if.d_source  = v.source;
      outer_if.d_data    = v.data[k];
      outer_if.d_denied  = v.denied[k];
      outer_if.d_corrupt = v.corrupt[k];
      inner_if.d_ready   = ($urandom_range(0, 2) != 0);
      #2;
      last = ((k % v.nper) == v.nper - 1);
      chk("in_d_valid", inner_if.d_valid, last);
      chk("out_d_ready", outer_if.d_ready, !last || inner_if.d_ready);
      if (last && inner_if.d_ready) begin
        e = d_q.pop_front();
        if (e.chk_data) chk("in_d_data", inner_if.d_data, e.data);
        chk("in_d_denied", inner_if.d_denied, e.denied);
        chk("in_d_corrupt", inner_if.d_corrupt, e.corrupt);
      end
      if (!last || inner_if.d_ready) k++;
      @(posedge clk);
      @(negedge clk);
      guard++;
    end
    chk("d_sub_beats_done", k, v.nout);
    outer_if.d_valid = 1'b0;
    inner_if.d_ready = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle_inputs();

    a_tab[0] = '{opcode: PUT_FULL, size: 3'd3, source: 2'd0, addr: 32'h100, mask: 8'hFF,
                 ninner: 1, nper: 2, data: {64'h0, 64'h1122334455667788},
                 exp_addr: {32'h0, 32'h0, 32'h104, 32'h100},
                 exp_data: {32'h0, 32'h0, 32'h11223344, 32'h55667788},
                 exp_mask: {4'h0, 4'h0, 4'hF, 4'hF}};
    a_tab[1] = '{opcode: PUT_PARTIAL, size: 3'd2, source: 2'd1, addr: 32'h104, mask: 8'hF0,
                 ninner: 1, nper: 1, data: {64'h0, 64'hAABBCCDD01020304},
                 exp_addr: {32'h0, 32'h0, 32'h0, 32'h104},
                 exp_data: {32'h0, 32'h0, 32'h0, 32'hAABBCCDD},
                 exp_mask: {4'h0, 4'h0, 4'h0, 4'hF}};
    a_tab[2] = '{opcode: GET, size: 3'd2, source: 2'd3, addr: 32'h0C, mask: 8'hF0,
                 ninner: 1, nper: 1, data: {64'h0, 64'h0},
                 exp_addr: {32'h0, 32'h0, 32'h0, 32'h0C},
                 exp_data: {32'h0, 32'h0, 32'h0, 32'h0},
                 exp_mask: {4'h0, 4'h0, 4'h0, 4'hF}};
    a_tab[3] = '{opcode: GET, size: 3'd4, source: 2'd1, addr: 32'h40, mask: 8'hFF,
                 ninner: 1, nper: 1, data: {64'h0, 64'h0},
                 exp_addr: {32'h0, 32'h0, 32'h0, 32'h40},
                 exp_data: {32'h0, 32'h0, 32'h0, 32'h0},
                 exp_mask: {4'h0, 4'h0, 4'h0, 4'hF}};
    a_tab[4] = '{opcode: PUT_PARTIAL, size: 3'd1, source: 2'd2, addr: 32'h106, mask: 8'hC0,
                 ninner: 1, nper: 1, data: {64'h0, 64'hBEEF000000000000},
                 exp_addr: {32'h0, 32'h0, 32'h0, 32'h106},
                 exp_data: {32'h0, 32'h0, 32'h0, 32'hBEEF0000},
                 exp_mask: {4'h0, 4'h0, 4'h0, 4'hC}};
    a_tab[5] = '{opcode: PUT_FULL, size: 3'd4, source: 2'd2, addr: 32'h200, mask: 8'hFF,
                 ninner: 2, nper: 2, data: {64'h0000000400000003, 64'h0000000200000001},
                 exp_addr: {32'h204, 32'h200, 32'h204, 32'h200},
                 exp_data: {32'h4, 32'h3, 32'h2, 32'h1},
                 exp_mask: {4'hF, 4'hF, 4'hF, 4'hF}};

    d_tab[0] = '{opcode: ACK_DATA, size: 3'd2, source: 2'd3, nout: 1, nper: 1,
                 data: {32'h0, 32'h0, 32'h0, 32'hDEADBEEF}, denied: 4'b0, corrupt: 4'b0,
                 exp_data: {64'h0, 64'hDEADBEEF00000000}, exp_denied: 2'b00,
                 exp_corrupt: 2'b00, chk_data: 1'b1};
    d_tab[1] = '{opcode: ACK_DATA, size: 3'd4, source: 2'd1, nout: 4, nper: 2,
                 data: {32'hDDDD0004, 32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001},
                 denied: 4'b0100, corrupt: 4'b0,
                 exp_data: {64'hDDDD0004CCCC0003, 64'hBBBB0002AAAA0001}, exp_denied: 2'b10,
                 exp_corrupt: 2'b00, chk_data: 1'b1};
    d_tab[2] = '{opcode: ACK, size: 3'd3, source: 2'd0, nout: 1, nper: 1,
                 data: {32'h0, 32'h0, 32'h0, 32'h0}, denied: 4'b0001, corrupt: 4'b0,
                 exp_data: {64'h0, 64'h0}, exp_denied: 2'b01,
                 exp_corrupt: 2'b00, chk_data: 1'b0};
    d_tab[3] = '{opcode: ACK_DATA, size: 3'd3, source: 2'd0, nout: 2, nper: 2,
                 data: {32'h0, 32'h0, 32'h22222222, 32'h11111111}, denied: 4'b0, corrupt: 4'b0001,
                 exp_data: {64'h0, 64'h2222222211111111}, exp_denied: 2'b00,
                 exp_corrupt: 2'b01, chk_data: 1'b1};
    d_tab[4] = '{opcode: ACK_DATA, size: 3'd0, source: 2'd3, nout: 1, nper: 1,
                 data: {32'h0, 32'h0, 32'h0, 32'h000000EE}, denied: 4'b0, corrupt: 4'b0,
                 exp_data: {64'h0, 64'h000000EE00000000}, exp_denied: 2'b00,
                 exp_corrupt: 2'b00, chk_data: 1'b1};

    // Outputs while held in reset.
    @(negedge clk);
    inner_if.a_valid  = 1'b1;
    inner_if.a_opcode = PUT_FULL;
    inner_if.a_size   = 3'd3;
    outer_if.a_ready  = 1'b1;
    #1;
    chk("rst_out_a_valid", outer_if.a_valid, 1);
    chk("rst_in_a_ready_n2", inner_if.a_ready, 0);
    inner_if.a_size = 3'd2;
    #1;
    chk("rst_in_a_ready_n1", inner_if.a_ready, 1);
    outer_if.a_ready = 1'b0;
    #1;
    chk("rst_in_a_ready_n1_stall", inner_if.a_ready, 0);
    outer_if.d_valid  = 1'b1;
    outer_if.d_opcode = ACK_DATA;
    outer_if.d_size   = 3'd3;
    inner_if.d_ready  = 1'b0;
    #1;
    chk("rst_in_d_valid_multi", inner_if.d_valid, 0);
    chk("rst_out_d_ready_multi", outer_if.d_ready, 1);
    outer_if.d_opcode = ACK;
    #1;
    chk("rst_in_d_valid_single", inner_if.d_valid, 1);
    chk("rst_out_d_ready_single", outer_if.d_ready, 0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) send_a(a_tab[i]);
    for (int i = 0; i < 5; i++) send_d(d_tab[i]);

    // Inner side stalls on the final sub-beat: gathered data must hold.
    outer_if.d_valid  = 1'b1;
    outer_if.d_opcode = ACK_DATA;
    outer_if.d_size   = 3'd3;
    outer_if.d_source = 2'd0;
    outer_if.d_data   = 32'h0BADF00D;
    inner_if.d_ready  = 1'b1;
    #2;
    chk("bp_first_in_d_valid", inner_if.d_valid, 0);
    chk("bp_first_out_d_ready", outer_if.d_ready, 1);
    @(posedge clk);
    @(negedge clk);
    outer_if.d_data  = 32'h600DCAFE;
    inner_if.d_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #2;
      chk("bp_hold_out_d_ready", outer_if.d_ready, 0);
      chk("bp_hold_in_d_valid", inner_if.d_valid, 1);
      chk("bp_hold_in_d_data", inner_if.d_data, 64'h600DCAFE0BADF00D);
      @(posedge clk);
      @(negedge clk);
    end
    inner_if.d_ready = 1'b1;
    #2;
    chk("bp_release_out_d_ready", outer_if.d_ready, 1);
    chk("bp_release_in_d_data", inner_if.d_data, 64'h600DCAFE0BADF00D);
    @(posedge clk);
    @(negedge clk);
    outer_if.d_size   = 3'd2;
    outer_if.d_source = 2'd3;
    outer_if.d_data   = 32'h5A5A5A5A;
    #2;
    chk("bp_next_in_d_valid", inner_if.d_valid, 1);
    chk("bp_next_in_d_data", inner_if.d_data, 64'h5A5A5A5A00000000);
    @(posedge clk);
    @(negedge clk);
    idle_inputs();

    // Reset lands after the first sub-beat of a PutFull.
    inner_if.a_valid   = 1'b1;
    inner_if.a_opcode  = PUT_FULL;
    inner_if.a_size    = 3'd3;
    inner_if.a_address = 32'h300;
    inner_if.a_mask    = 8'hFF;
    inner_if.a_data    = 64'hCAFEF00D12345678;
    outer_if.a_ready   = 1'b1;
    #2;
    chk("mid_beat0_data", outer_if.a_data, 32'h12345678);
    chk("mid_beat0_in_a_ready", inner_if.a_ready, 0);
    @(posedge clk);
    @(negedge clk);
    outer_if.a_ready = 1'b0;
    #2;
    chk("mid_beat1_data", outer_if.a_data, 32'hCAFEF00D);
    chk("mid_beat1_address", outer_if.a_address, 32'h304);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_data", outer_if.a_data, 32'h12345678);
    chk("mid_rst_address", outer_if.a_address, 32'h300);
    @(negedge clk);
    rst_n = 1'b1;
    inner_if.a_data  = 64'h876543210FEDCBA9;
    outer_if.a_ready = 1'b1;
    #2;
    chk("post_rst_beat0_data", outer_if.a_data, 32'h0FEDCBA9);
    chk("post_rst_beat0_in_a_ready", inner_if.a_ready, 0);
    @(posedge clk);
    @(negedge clk);
    #2;
    chk("post_rst_beat1_data", outer_if.a_data, 32'h87654321);
    chk("post_rst_beat1_in_a_ready", inner_if.a_ready, 1);
    @(posedge clk);
    @(negedge clk);
    idle_inputs();

    chk("a_queue_drained", a_q.size(), 0);
    chk("d_queue_drained", d_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
